delay_tap: RTL

//   RAM-backed circular delay line with a run-time programmable read tap, for echo/reverb/comb paths.
//   - Writes one audio sample per enable strobe (sample-rate tick).
//   - Returns the sample written exactly `delay` strobes earlier.
//   - Reader-side counterpart of the fixed-length shift-register fifo.
//   - Depth is large enough for block RAM, so it is cleared by a sequential sweep, not by a flop reset.

---
 rtl/audio_pkg.sv | 13 +
 rtl/delay_tap_if.sv | 24 ++
 rtl/delay_ram.sv | 33 +++
 rtl/delay_tap.sv | 112 +++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants, sample type and delay-line state encoding.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 12;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } delay_state_t;

endpackage : audio_pkg

// File: rtl/delay_tap_if.sv
// Sample-stream bundle between a producer/consumer (master) and the delay tap (slave).
interface delay_tap_if #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 10
);

  logic              enable;
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] delay;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;

  modport master (
    output enable, in, delay,
    input  out, out_valid, busy
  );

  modport slave (
    input  enable, in, delay,
    output out, out_valid, busy
  );

endinterface : delay_tap_if

// File: rtl/delay_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module delay_ram #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: no reset on the array or its read register, so synthesis can map it onto block RAM;
  // initial contents come from the controller's clear sweep instead.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : delay_ram

// File: rtl/delay_tap.sv
// Circular delay line with a programmable read tap; after reset the RAM is swept to zero,
// then each enable strobe writes one sample and returns the one written `delay` strobes earlier.
module delay_tap
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  delay_tap_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  delay_state_t      r_state;
  delay_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_out_valid;
  logic              r_have;
  logic              r_byp_sel;
  logic [WIDTH-1:0]  r_byp_data;

  logic              w_busy;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [ADDR_W-1:0] w_raddr;
  logic [WIDTH-1:0]  w_rdata;
  logic [WIDTH-1:0]  w_out;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_clr_addr == LAST_ADDR) begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_busy   = (r_state == CLEAR);
    w_accept = (r_state == RUN) && bus.enable;
    w_we     = w_busy || w_accept;
    w_waddr  = w_busy ? r_clr_addr : r_wr_ptr;
    w_wdata  = w_busy ? '0 : bus.in;
  end

  // Unsigned wrap-around gives the modulo-DEPTH tap address directly.
  assign w_raddr = r_wr_ptr - bus.delay;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_clr_addr  <= '0;
      r_out_valid <= 1'b0;
      r_have      <= 1'b0;
      r_byp_sel   <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_busy) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_have     <= 1'b1;
        r_byp_sel  <= (bus.delay == '0);
        r_byp_data <= bus.in;
      end
    end
  end

  delay_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // RAM read register is not reset, so output is forced to 0 until the first accepted strobe;
  // a zero tap reads the RAM's old word, so the fresh sample is muxed in instead.
  always_comb begin
    w_out = '0;
    if (r_have) begin
      w_out = r_byp_sel ? r_byp_data : w_rdata;
    end
  end

  assign bus.out       = w_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = w_busy;

endmodule : delay_tap
